// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: beam position counters, registered sync/blanking
// decode aligned with x/y, line/frame start strobes and a completed-frame counter.
module vga_timing_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter logic        SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // Window bounds are 11 bits so an end bound equal to 1024 still compares correctly.
    localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
    localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [7:0] fc_q, fc_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       de_q, de_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;
    logic       x_wrap_s;
    logic       y_last_s;

    // Next beam position, strobes and sync/blank decode of that next position.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        fc_d     = fc_q;
        ls_d     = 1'b0;
        fs_d     = 1'b0;
        x_wrap_s = (x_q == H_LAST);
        y_last_s = (y_q == V_LAST);

        if (pix_en) begin
            if (x_wrap_s) begin
                x_d  = 10'd0;
                ls_d = 1'b1;
                if (y_last_s) begin
                    y_d  = 10'd0;
                    fc_d = fc_q + 8'd1;
                    fs_d = 1'b1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end else begin
            x_d = x_q;
        end

        if (({1'b0, x_d} >= HS_START) && ({1'b0, x_d} < HS_END)) begin
            hs_d = SYNC_POL;
        end else begin
            hs_d = ~SYNC_POL;
        end

        if (({1'b0, y_d} >= VS_START) && ({1'b0, y_d} < VS_END)) begin
            vs_d = SYNC_POL;
        end else begin
            vs_d = ~SYNC_POL;
        end

        de_d = ({1'b0, x_d} < H_VIS) && ({1'b0, y_d} < V_VIS);
    end

    // State and output registers; reset parks the beam at the visible origin.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q  <= 10'd0;
            y_q  <= 10'd0;
            fc_q <= 8'd0;
            hs_q <= ~SYNC_POL;
            vs_q <= ~SYNC_POL;
            de_q <= 1'b1;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            fc_q <= fc_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            de_q <= de_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign frame_count = fc_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign display_on  = de_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a reduced-geometry instance (15x10 raster) for
// frame-level scenarios and a default-geometry instance for one full 800-pixel line.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Reduced instance: H 8+2+3+2=15 (hsync x 10..12), V 6+1+2+1=10 (vsync y 7..8).
    logic       reset  = 1'b1;
    logic       pix_en = 1'b0;
    logic [9:0] x, y;
    logic       hsync, vsync, display_on, line_start, frame_start;
    logic [7:0] frame_count;

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .x(x), .y(y), .hsync(hsync), .vsync(vsync), .display_on(display_on),
        .line_start(line_start), .frame_start(frame_start), .frame_count(frame_count)
    );

    // Default-geometry instance.
    logic       reset_b  = 1'b1;
    logic       pix_en_b = 1'b0;
    logic [9:0] bx, by;
    logic       bhs, bvs, bde, bls, bfs;
    logic [7:0] bfc;

    vga_timing_gen dut_b (
        .clk(clk), .reset(reset_b), .pix_en(pix_en_b),
        .x(bx), .y(by), .hsync(bhs), .vsync(bvs), .display_on(bde),
        .line_start(bls), .frame_start(bfs), .frame_count(bfc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst;
        logic       pe;
        int         n;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs, vs, de, ls, fs;
        logic [7:0] fc;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t mk(input logic rst, input logic pe, input int n,
                                input int ex, input int ey, input logic hs, input logic vs,
                                input logic de, input logic ls, input logic fs, input int fc);
        vec_t v;
        v.rst = rst; v.pe = pe; v.n = n;
        v.x = 10'(ex); v.y = 10'(ey);
        v.hs = hs; v.vs = vs; v.de = de; v.ls = ls; v.fs = fs;
        v.fc = 8'(fc);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] got_s();
        return {6'd0, x, y, hsync, vsync, display_on, line_start, frame_start, frame_count};
    endfunction

    // Expected packed outputs of the reduced instance after n enabled cycles from reset.
    function automatic logic [39:0] model_s(input int n);
        int  px, py, fc;
        logic hs, vs, de, ls, fs;
        px = n % 15;
        py = (n / 15) % 10;
        fc = (n / 150) % 256;
        hs = !(px >= 10 && px < 13);
        vs = !(py >= 7 && py < 9);
        de = (px < 8) && (py < 6);
        ls = (n > 0) && (px == 0);
        fs = (n > 0) && (n % 150 == 0);
        return {6'd0, 10'(px), 10'(py), hs, vs, de, ls, fs, 8'(fc)};
    endfunction

    initial begin
        // Default geometry: reset, then one full line plus the wrap into line 1.
        step();
        chk("b_reset", {bx, by, bhs, bvs, bde, bls, bfs, bfc},
            {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        reset_b  = 1'b0;
        pix_en_b = 1'b1;
        for (int n = 1; n <= 801; n++) begin
            int px;
            step();
            px = n % 800;
            chk($sformatf("b_line n=%0d", n), {bx, by, bhs, bvs, bde, bls, bfs},
                {10'(px), 10'(n / 800), !(px >= 656 && px <= 751), 1'b1,
                 (px < 640), (n == 800), 1'b0});
        end

        // Reduced geometry: directed table.
        tbl[0]  = mk(1, 1, 1,   0, 0, 1, 1, 1, 0, 0, 0);
        tbl[1]  = mk(1, 0, 2,   0, 0, 1, 1, 1, 0, 0, 0);
        tbl[2]  = mk(0, 1, 1,   1, 0, 1, 1, 1, 0, 0, 0);
        tbl[3]  = mk(0, 0, 3,   1, 0, 1, 1, 1, 0, 0, 0);
        tbl[4]  = mk(0, 1, 6,   7, 0, 1, 1, 1, 0, 0, 0);
        tbl[5]  = mk(0, 1, 1,   8, 0, 1, 1, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 2,  10, 0, 0, 1, 0, 0, 0, 0);
        tbl[7]  = mk(0, 1, 2,  12, 0, 0, 1, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 2,  12, 0, 0, 1, 0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 1,  13, 0, 1, 1, 0, 0, 0, 0);
        tbl[10] = mk(0, 1, 1,  14, 0, 1, 1, 0, 0, 0, 0);
        tbl[11] = mk(0, 1, 1,   0, 1, 1, 1, 1, 1, 0, 0);
        tbl[12] = mk(0, 0, 1,   0, 1, 1, 1, 1, 0, 0, 0);
        tbl[13] = mk(0, 1, 1,   1, 1, 1, 1, 1, 0, 0, 0);
        tbl[14] = mk(0, 1, 66,  7, 5, 1, 1, 1, 0, 0, 0);
        tbl[15] = mk(0, 1, 1,   8, 5, 1, 1, 0, 0, 0, 0);
        tbl[16] = mk(0, 1, 7,   0, 6, 1, 1, 0, 1, 0, 0);
        tbl[17] = mk(0, 1, 15,  0, 7, 1, 0, 0, 1, 0, 0);
        tbl[18] = mk(0, 1, 29, 14, 8, 1, 0, 0, 0, 0, 0);
        tbl[19] = mk(0, 1, 1,   0, 9, 1, 1, 0, 1, 0, 0);
        tbl[20] = mk(0, 1, 14, 14, 9, 1, 1, 0, 0, 0, 0);
        tbl[21] = mk(0, 0, 5,  14, 9, 1, 1, 0, 0, 0, 0);
        tbl[22] = mk(0, 1, 1,   0, 0, 1, 1, 1, 1, 1, 1);
        tbl[23] = mk(0, 0, 1,   0, 0, 1, 1, 1, 0, 0, 1);
        tbl[24] = mk(0, 1, 1,   1, 0, 1, 1, 1, 0, 0, 1);
        tbl[25] = mk(0, 1, 50,  6, 3, 1, 1, 1, 0, 0, 1);
        tbl[26] = mk(1, 1, 1,   0, 0, 1, 1, 1, 0, 0, 0);

        for (int i = 0; i < 27; i++) begin
            reset  = tbl[i].rst;
            pix_en = tbl[i].pe;
            repeat (tbl[i].n) step();
            chk($sformatf("vec%0d", i), got_s(),
                {6'd0, tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs, tbl[i].de,
                 tbl[i].ls, tbl[i].fs, tbl[i].fc});
        end

        // Free run over three frames, then reset mid-frame with frame_count at 3.
        reset = 1'b1; pix_en = 1'b1;
        step();
        reset = 1'b0;
        for (int n = 1; n <= 500; n++) begin
            step();
            chk($sformatf("free n=%0d", n), got_s(), model_s(n));
        end
        reset = 1'b1;
        step();
        chk("mid_reset", got_s(), {6'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});

        // 256 frames: frame_count must step on every frame_start and wrap 255 -> 0.
        reset = 1'b0;
        for (int n = 1; n <= 256 * 150; n++) begin
            step();
            chk($sformatf("wrap n=%0d", n), {30'd0, frame_start, frame_count},
                {30'd0, (n % 150 == 0), 8'((n / 150) % 256)});
        end
        chk("wrap_final", {x, y, frame_start, line_start, frame_count},
            {10'd0, 10'd0, 1'b1, 1'b1, 8'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
